fpu_issue_arbiter: RTL and testbench

//  Shares one combinational FloatingPointUnit between two requesters (req0 = integer-pipe COP1 issue,
//  req1 = FP microcode/divide helper). Grants round-robin, registers operands, holds them on the FPU
//  for LATENCY cycles (multicycle path), captures the result, returns it with valid/ready handshake.

---
 rtl/fpu_issue_arbiter_pkg.sv | 37 +++
 rtl/fpu_issue_arbiter_fpu.sv | 104 ++++++++++
 rtl/fpu_issue_arbiter_rr_arbiter.sv | 25 ++
 rtl/fpu_issue_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_arbiter_pkg.sv
// ============================================================================
// Module  : fpu_issue_arbiter_pkg
// Brief   : FPU command encodings, issue-arbiter FSM states and a helper
//           leading-zero counter. The command and state encodings are also
//           used by the COP1 decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_issue_arbiter_pkg;

  // FPU command encodings (cmd field of each request)
  localparam logic [3:0] FPU_CMD_ADD = 4'd0;
  localparam logic [3:0] FPU_CMD_SUB = 4'd1;
  localparam logic [3:0] FPU_CMD_NEG = 4'd2;
  localparam logic [3:0] FPU_CMD_ABS = 4'd3;

  // Issue arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Leading zeros of a 27-bit normalisation window (27 when the input is zero)
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_issue_arbiter_fpu.sv
// ============================================================================
// Module  : FloatingPointUnit
// Brief   : Combinational IEEE-754 single-precision unit. ADD/SUB with
//           round-to-nearest-even, NEG and ABS; other commands return zero.
//           Denormal inputs and underflowing results are flushed to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module FloatingPointUnit
  import fpu_issue_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  cmd,
  output logic [31:0] result
);

  logic [31:0]       w_b_eff, w_x, w_y, w_add;
  logic [23:0]       w_mx, w_my;
  logic [7:0]        w_d;
  logic [26:0]       w_al, w_sh, w_sm, w_n;
  logic              w_lost, w_sub, w_inc;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic signed [9:0] w_e;
  logic [24:0]       w_r;

  // Add/subtract datapath: order by magnitude, align, add, normalise, round
  always_comb begin
    w_b_eff = (cmd == FPU_CMD_SUB) ? {~b[31], b[30:0]} : b;
    w_x     = (w_b_eff[30:0] > a[30:0]) ? w_b_eff : a;
    w_y     = (w_b_eff[30:0] > a[30:0]) ? a : w_b_eff;
    w_mx    = (w_x[30:23] == 8'd0) ? 24'd0 : {1'b1, w_x[22:0]};
    w_my    = (w_y[30:23] == 8'd0) ? 24'd0 : {1'b1, w_y[22:0]};
    w_d     = w_x[30:23] - w_y[30:23];
    w_sub   = w_x[31] ^ w_y[31];
    w_al    = {w_my, 3'b000};
    w_sh    = 27'd0;
    w_lost  = 1'b0;
    w_sm    = 27'd0;
    w_lz    = 5'd0;
    w_n     = 27'd0;
    w_e     = 10'sd0;
    w_inc   = 1'b0;
    w_r     = 25'd0;
    w_add   = 32'd0;
    // Alignment keeps a sticky bit so rounding sees everything shifted out
    if (w_d >= 8'd27) begin
      w_sm = {26'd0, |w_my};
    end else begin
      w_sh   = w_al >> w_d;
      w_lost = |(w_al & ((27'd1 << w_d) - 27'd1));
      w_sm   = {w_sh[26:1], w_sh[0] | w_lost};
    end
    w_sum = w_sub ? ({1'b0, w_mx, 3'b000} - {1'b0, w_sm})
                  : ({1'b0, w_mx, 3'b000} + {1'b0, w_sm});
    w_e   = signed'({2'b00, w_x[30:23]});
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = w_e + 10'sd1;
    end else begin
      w_lz = lzc27(w_sum[26:0]);
      w_n  = w_sum[26:0] << w_lz;
      w_e  = w_e - signed'({5'd0, w_lz});
    end
    // Round to nearest, ties to even; a carry out renormalises by one
    w_inc = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_r   = {1'b0, w_n[26:3]} + {24'd0, w_inc};
    if (w_r[24]) begin
      w_r = w_r >> 1;
      w_e = w_e + 10'sd1;
    end
    if ((w_x[30:23] == 8'hFF) || (w_y[30:23] == 8'hFF)) begin
      if ((w_x[30:23] == 8'hFF && w_x[22:0] != 23'd0) ||
          (w_y[30:23] == 8'hFF && w_y[22:0] != 23'd0) ||
          (w_y[30:23] == 8'hFF && w_sub))
        w_add = 32'h7FC0_0000;
      else
        w_add = w_x;
    end else if (w_sum == 28'd0) begin
      w_add = {w_x[31] & w_y[31], 31'd0};
    end else if (w_e <= 10'sd0) begin
      w_add = {w_x[31], 31'd0};
    end else if (w_e >= 10'sd255) begin
      w_add = {w_x[31], 8'hFF, 23'd0};
    end else begin
      w_add = {w_x[31], w_e[7:0], w_r[22:0]};
    end
  end

  // Command decode
  always_comb begin
    case (cmd)
      FPU_CMD_ADD, FPU_CMD_SUB: result = w_add;
      FPU_CMD_NEG:              result = {~a[31], a[30:0]};
      FPU_CMD_ABS:              result = {1'b0, a[30:0]};
      default:                  result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fpu_issue_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : fpu_rr_arbiter
// Brief   : 2-way round-robin grant. A lone valid requester wins; on a tie
//           the priority pointer picks the winner (0 -> req0, 1 -> req1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_rr_arbiter (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ptr,
  output logic o_grant0,
  output logic o_grant1
);

  // Grants are mutually exclusive by construction
  always_comb begin
    o_grant0 = i_valid0 & (~i_valid1 | ~i_ptr);
    o_grant1 = i_valid1 & (~i_valid0 |  i_ptr);
  end

endmodule

`default_nettype wire

// File: rtl/fpu_issue_arbiter.sv
// ============================================================================
// Module  : fpu_issue_arbiter
// Brief   : Shares one combinational FloatingPointUnit between the COP1 issue
//           port (req0) and the FP microcode helper (req1). Round-robin grant,
//           operands held LATENCY cycles (multicycle path), single outstanding
//           op, result returned on a valid/ready response channel.
//           Optional: FPU_ARB_STATS_EN adds per-requester grant counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_arbiter
  import fpu_issue_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CMD_W   = 4,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CMD_W-1:0] req1_cmd,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef FPU_ARB_STATS_EN
  output logic [31:0]      grant_cnt0,
  output logic [31:0]      grant_cnt1,
`endif
  output logic             busy
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_t       r_state, w_state_nxt;
  logic             r_ptr, r_src;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_fpu_result;
  logic [CMD_W-1:0] r_cmd;
  logic [TAG_W-1:0] r_tag;
  logic             w_grant0, w_grant1, w_accept;

  fpu_rr_arbiter u_rr_arbiter (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_ptr    (r_ptr),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  // The FPU sees only the latched operands, so its path has LATENCY cycles
  FloatingPointUnit u_fpu (
    .a      (r_a),
    .b      (r_b),
    .cmd    (r_cmd),
    .result (w_fpu_result)
  );

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        w_accept   = w_grant0 | w_grant1;
        if (w_accept) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Priority pointer: loser of the last grant wins the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_ptr <= 1'b0;
    else if (r_state == ST_RESP && rsp_ready)   r_ptr <= ~r_src;
  end

  // Hold counter for the multicycle FPU path
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_cnt <= '0;
    else if (w_accept)                          r_cnt <= CNT_LOAD;
    else if (r_state == ST_EXEC && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  end

  // Operand capture on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cmd <= '0;
      r_tag <= '0;
      r_src <= 1'b0;
    end else if (w_accept) begin
      r_a   <= w_grant1 ? req1_a   : req0_a;
      r_b   <= w_grant1 ? req1_b   : req0_b;
      r_cmd <= w_grant1 ? req1_cmd : req0_cmd;
      r_tag <= w_grant1 ? req1_tag : req0_tag;
      r_src <= w_grant1;
    end
  end

  // Result capture at the end of the hold window
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_result <= '0;
    else if (r_state == ST_EXEC && r_cnt == '0) r_result <= w_fpu_result;
  end

  assign rsp_result = r_result;
  assign rsp_src    = r_src;
  assign rsp_tag    = r_tag;

`ifdef FPU_ARB_STATS_EN
  logic [31:0] r_grant_cnt0, r_grant_cnt1;

  // Per-requester accept counters, wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_cnt0 <= 32'd0;
      r_grant_cnt1 <= 32'd0;
    end else if (w_accept) begin
      if (w_grant0) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (w_grant1) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
// ============================================================================
// Module  : tb_fpu_issue_arbiter
// Brief   : Directed bench for fpu_issue_arbiter with a response scoreboard.
//           Build with FPU_ARB_STATS_EN to also cover the grant counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_arbiter;

  localparam int LATENCY = 2;

  typedef struct packed {
    logic [31:0] res;
    logic        src;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_cmd = '0, req1_cmd = '0;
  logic [4:0]  req0_tag = '0, req1_tag = '0;
  logic        rsp_valid, rsp_src, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
`ifdef FPU_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  fpu_issue_arbiter #(.WIDTH(32), .CMD_W(4), .TAG_W(5), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cmd   (req0_cmd),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cmd   (req1_cmd),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag),
`ifdef FPU_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op on one requester (called at a negedge)
  task automatic set_req(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cmd, input logic [4:0] tag);
    if (!s) begin
      req0_a = a; req0_b = b; req0_cmd = cmd; req0_tag = tag; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cmd = cmd; req1_tag = tag; req1_valid = 1'b1;
    end
  endtask

  // Wait for ready on requester s, push the expected response, drop valid
  task automatic accept_one(input string name, input bit s, input logic [31:0] exp);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #2;
      if ((s ? req1_ready : req0_ready) === 1'b1) begin
        sb.push_back('{res: exp, src: s, tag: (s ? req1_tag : req0_tag)});
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (s) req1_valid = 1'b0; else req0_valid = 1'b0;
        done = 1'b1;
      end
      @(negedge clk);
    end
    chk({name, "_accept"}, 32'(done), 32'd1);
  endtask

  // Take the next response and compare it with the scoreboard head
  task automatic get_rsp(input string name, input int exp_lat);
    bit   done = 1'b0;
    exp_t e;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        chk({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({name, "_result"}, rsp_result, e.res);
          chk({name, "_src"}, 32'(rsp_src), 32'(e.src));
          chk({name, "_tag"}, 32'(rsp_tag), 32'(e.tag));
          if (exp_lat > 0) chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
        end
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    chk({name, "_rsp_seen"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_src", 32'(rsp_src), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
`ifdef FPU_ARB_STATS_EN
    chk("rst_gcnt0", grant_cnt0, 32'd0);
    chk("rst_gcnt1", grant_cnt1, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 1: req0 ADD 3.14 + 0
    set_req(0, 32'h4048F5C3, 32'h0, 4'd0, 5'd3);
    accept_one("t1", 0, 32'h4048F5C3);
    #1;
    chk("t1_busy_exec", 32'(busy), 32'd1);
    get_rsp("t1", LATENCY + 1);

    // 2: req1 ADD 3.14 + 3.14, tag 7
    set_req(1, 32'h4048F5C3, 32'h4048F5C3, 4'd0, 5'd7);
    accept_one("t2", 1, 32'h40C8F5C3);
    get_rsp("t2", LATENCY + 1);

    // Further arithmetic patterns
    set_req(0, 32'h40C8F5C3, 32'h4048F5C3, 4'd1, 5'd1);
    accept_one("sub", 0, 32'h4048F5C3);
    get_rsp("sub", LATENCY + 1);
    set_req(1, 32'h3FC00000, 32'h3E800000, 4'd0, 5'd2);
    accept_one("align", 1, 32'h3FE00000);
    get_rsp("align", LATENCY + 1);
    set_req(0, 32'h3F800000, 32'h3F800000, 4'd1, 5'd31);
    accept_one("cancel", 0, 32'h00000000);
    get_rsp("cancel", LATENCY + 1);
    set_req(1, 32'h3F800000, 32'h0, 4'd2, 5'd9);
    accept_one("neg", 1, 32'hBF800000);
    get_rsp("neg", LATENCY + 1);

    // 3: tie from reset, round-robin alternation
    pulse_reset();
    set_req(0, 32'h4048F5C3, 32'h40C8F5C3, 4'd0, 5'd10);
    set_req(1, 32'h4048F5C3, 32'h40C8F5C3, 4'd0, 5'd11);
    #2;
    chk("t3_tie1_r0", 32'(req0_ready), 32'd1);
    chk("t3_tie1_r1", 32'(req1_ready), 32'd0);
    accept_one("t3a", 0, 32'h4116B852);
    get_rsp("t3a", LATENCY + 1);
    accept_one("t3b", 1, 32'h4116B852);
    get_rsp("t3b", LATENCY + 1);
    set_req(0, 32'h4048F5C3, 32'h40C8F5C3, 4'd0, 5'd12);
    set_req(1, 32'h4048F5C3, 32'h40C8F5C3, 4'd0, 5'd13);
    #2;
    chk("t3_tie3_r0", 32'(req0_ready), 32'd1);
    chk("t3_tie3_r1", 32'(req1_ready), 32'd0);
    accept_one("t3c", 0, 32'h4116B852);
    get_rsp("t3c", LATENCY + 1);
    req1_valid = 1'b0;

    // 4: back-pressure holds RESP with stable outputs
    rsp_ready = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000, 4'd0, 5'd5);
    accept_one("t4", 0, 32'h40400000);
    set_req(1, 32'h3F800000, 32'h3F800000, 4'd0, 5'd6);
    req0_valid = 1'b1;
    for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_result", rsp_result, 32'h40400000);
      chk("t4_hold_tag", 32'(rsp_tag), 32'd5);
      chk("t4_hold_r0", 32'(req0_ready), 32'd0);
      chk("t4_hold_r1", 32'(req1_ready), 32'd0);
      chk("t4_hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    get_rsp("t4", 0);

    // 5: reset mid-EXEC discards the op
    set_req(1, 32'h3F800000, 32'h3F800000, 4'd0, 5'd20);
    accept_one("t5", 1, 32'h40000000);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    set_req(0, 32'h3F800000, 32'h3F800000, 4'd0, 5'd21);
    set_req(1, 32'h3F800000, 32'h3F800000, 4'd0, 5'd22);
    #2;
    chk("t5_ptr_reset_r0", 32'(req0_ready), 32'd1);
    accept_one("t5b", 0, 32'h40000000);
    req1_valid = 1'b0;
    get_rsp("t5b", LATENCY + 1);

    // 6: three req0 and two req1 ops after a fresh reset
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      bit s = (k >= 3);
      set_req(s, 32'h3F800000, 32'h40000000, 4'd0, 5'(k));
      accept_one("t6", s, 32'h40400000);
      get_rsp("t6", LATENCY + 1);
    end
`ifdef FPU_ARB_STATS_EN
    chk("t6_gcnt0", grant_cnt0, 32'd3);
    chk("t6_gcnt1", grant_cnt1, 32'd2);
    pulse_reset();
    #1;
    chk("t6_gcnt0_clr", grant_cnt0, 32'd0);
    chk("t6_gcnt1_clr", grant_cnt1, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
